// File: rtl/divfreq_pkg.sv
// Shared constants for the game clock-divider bank.
// Limits are half-period counts (half period = limit + 1 CLK cycles).
package divfreq_pkg;

   // Half-period limits for each timing need
   localparam int unsigned LIM_CTRL   = 5500000;
   localparam int unsigned LIM_BLUE   = 2500000;
   localparam int unsigned LIM_GREEN  = 2000000;
   localparam int unsigned LIM_SCAN   = 50000;
   localparam int unsigned LIM_RAND_B = 123456;
   localparam int unsigned LIM_RAND_G = 654321;
   localparam int unsigned LIM_TIMER  = 55000000;

   // Channel assignment within the bank
   localparam int unsigned CH_CTRL    = 0;
   localparam int unsigned CH_BLUE    = 1;
   localparam int unsigned CH_GREEN   = 2;
   localparam int unsigned CH_SCAN    = 3;
   localparam int unsigned CH_RAND_B  = 4;
   localparam int unsigned CH_RAND_G  = 5;
   localparam int unsigned CH_TIMER   = 6;

endpackage

// File: rtl/divfreq_chan.sv
// One clock-divider channel: 50%-duty divided level plus a 1-cycle tick on its rising edge.
// Ports:
//   CLK     system clock (posedge)
//   RST_N   asynchronous active-low reset
//   en      run enable; 0 holds count and level
//   sync    restart at phase 0 (overrides en)
//   ld      load strobe for ld_val into the half-period limit
//   ld_val  new half-period limit
//   clk_div divided clock level (registered)
//   tick    1-cycle strobe coincident with clk_div 0->1
module divfreq_chan #(
   parameter int unsigned   CW   = 30,
   parameter logic [CW-1:0] LIM0 = '0
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          en,
   input  logic          sync,
   input  logic          ld,
   input  logic [CW-1:0] ld_val,
   output logic          clk_div,
   output logic          tick
);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] lim_q, lim_d;
   logic          div_q, div_d;
   logic          tick_q, tick_d;
   logic          wrap;

   always_comb begin
      // >= so a limit lowered below the running count wraps immediately
      wrap   = (cnt_q >= lim_q);
      // compare this cycle uses lim_q; a load only affects later cycles
      lim_d  = ld ? ld_val : lim_q;
      cnt_d  = cnt_q;
      div_d  = div_q;
      tick_d = 1'b0;
      if (sync) begin
         cnt_d = '0;
         div_d = 1'b0;
      end else if (en) begin
         if (wrap) begin
            cnt_d  = '0;
            div_d  = ~div_q;
            tick_d = ~div_q;
         end else begin
            cnt_d  = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q  <= '0;
         lim_q  <= LIM0;
         div_q  <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         lim_q  <= lim_d;
         div_q  <= div_d;
         tick_q <= tick_d;
      end
   end

   assign clk_div = div_q;
   assign tick    = tick_q;

endmodule

// File: rtl/divfreq_bank.sv
// Bank of NCH independent clock dividers sharing one CLK, with run-time loadable limits.
// Ports:
//   CLK      system clock (posedge)
//   RST_N    asynchronous active-low reset
//   EN       per-channel run enable
//   SYNC     1-cycle pulse restarting all channels at phase 0
//   LD_EN    limit load strobe
//   LD_CH    channel index for load; indices >= NCH are ignored
//   LD_VAL   new half-period limit
//   CLK_DIV  divided clock levels (registered)
//   TICK     1-cycle strobes on each CLK_DIV rising edge
module divfreq_bank
   import divfreq_pkg::*;
#(
   parameter int unsigned        NCH      = 7,
   parameter int unsigned        CW       = 30,
   parameter logic [NCH*CW-1:0]  LIM_INIT = {NCH{CW'(LIM_TIMER)}}
) (
   input  logic           CLK,
   input  logic           RST_N,
   input  logic [NCH-1:0] EN,
   input  logic           SYNC,
   input  logic           LD_EN,
   input  logic [3:0]     LD_CH,
   input  logic [CW-1:0]  LD_VAL,
   output logic [NCH-1:0] CLK_DIV,
   output logic [NCH-1:0] TICK
);

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      logic ld;

      // out-of-range LD_CH matches no channel, so the load is dropped
      assign ld = LD_EN && (LD_CH == 4'(i));

      divfreq_chan #(
         .CW   (CW),
         .LIM0 (LIM_INIT[i*CW +: CW])
      ) u_chan (
         .CLK     (CLK),
         .RST_N   (RST_N),
         .en      (EN[i]),
         .sync    (SYNC),
         .ld      (ld),
         .ld_val  (LD_VAL),
         .clk_div (CLK_DIV[i]),
         .tick    (TICK[i])
      );
   end

endmodule

// File: tb/tb_divfreq_bank.sv
// Self-checking bench for divfreq_bank with NCH=3, CW=8, limits {2,1,0}.
module tb_divfreq_bank;

   localparam int NCH = 3;
   localparam int CW  = 8;

   logic           CLK = 1'b0;
   logic           RST_N;
   logic [NCH-1:0] EN;
   logic           SYNC;
   logic           LD_EN;
   logic [3:0]     LD_CH;
   logic [CW-1:0]  LD_VAL;
   logic [NCH-1:0] CLK_DIV;
   logic [NCH-1:0] TICK;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model: elapsed cycles in the current half period, limit and level per channel
   int       m_elap [NCH];
   int       m_lim  [NCH];
   bit [2:0] m_div;
   bit [2:0] m_tick;
   int       tick_cnt [NCH];
   int       first_tick [NCH];

   divfreq_bank #(
      .NCH      (NCH),
      .CW       (CW),
      .LIM_INIT ({8'd2, 8'd1, 8'd0})
   ) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .EN      (EN),
      .SYNC    (SYNC),
      .LD_EN   (LD_EN),
      .LD_CH   (LD_CH),
      .LD_VAL  (LD_VAL),
      .CLK_DIV (CLK_DIV),
      .TICK    (TICK)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_lim  = '{0, 1, 2};
      m_elap = '{0, 0, 0};
      m_div  = '0;
      m_tick = '0;
   endfunction

   // One CLK edge of the specified behaviour, from the inputs currently applied
   function automatic void model_step();
      for (int i = 0; i < NCH; i++) begin
         int new_lim;
         new_lim   = (LD_EN && int'(LD_CH) == i) ? int'(LD_VAL) : m_lim[i];
         m_tick[i] = 1'b0;
         if (SYNC) begin
            m_elap[i] = 0;
            m_div[i]  = 1'b0;
         end else if (EN[i]) begin
            // half period ends once elapsed reaches the limit in force this cycle
            if (m_elap[i] >= m_lim[i]) begin
               m_elap[i] = 0;
               m_tick[i] = !m_div[i];
               m_div[i]  = !m_div[i];
            end else begin
               m_elap[i] = m_elap[i] + 1;
            end
         end
         m_lim[i] = new_lim;
      end
   endfunction

   // Inputs are changed only between negedge and posedge; outputs sampled at negedge
   task automatic cycle();
      @(posedge CLK);
      if (RST_N) model_step();
      @(negedge CLK);
      check_eq("clk_div", 32'(CLK_DIV), 32'(m_div));
      check_eq("tick", 32'(TICK), 32'(m_tick));
   endtask

   task automatic idle_inputs();
      EN     = '1;
      SYNC   = 1'b0;
      LD_EN  = 1'b0;
      LD_CH  = '0;
      LD_VAL = '0;
   endtask

   // From phase 0 with reset limits {0,1,2}: 12 cycles give 6, 3, 2 ticks
   task automatic run_ticks(input string tag);
      for (int i = 0; i < NCH; i++) tick_cnt[i] = 0;
      repeat (12) begin
         cycle();
         for (int i = 0; i < NCH; i++) tick_cnt[i] += int'(TICK[i]);
      end
      check_eq({tag, "_ticks0"}, 32'(tick_cnt[0]), 32'd6);
      check_eq({tag, "_ticks1"}, 32'(tick_cnt[1]), 32'd3);
      check_eq({tag, "_ticks2"}, 32'(tick_cnt[2]), 32'd2);
   endtask

   // After SYNC, first tick on channel i arrives lim[i]+1 cycles later
   task automatic first_ticks(input string tag, input int l0, input int l1, input int l2);
      for (int i = 0; i < NCH; i++) first_tick[i] = 0;
      for (int c = 1; c <= 6; c++) begin
         cycle();
         for (int i = 0; i < NCH; i++)
            if (TICK[i] && first_tick[i] == 0) first_tick[i] = c;
      end
      check_eq({tag, "_first0"}, 32'(first_tick[0]), 32'(l0 + 1));
      check_eq({tag, "_first1"}, 32'(first_tick[1]), 32'(l1 + 1));
      check_eq({tag, "_first2"}, 32'(first_tick[2]), 32'(l2 + 1));
   endtask

   // Asynchronous reset applied mid-cycle, released at a negedge
   task automatic async_reset(input string tag);
      #2 RST_N = 1'b0;
      #1;
      check_eq({tag, "_rst_div"}, 32'(CLK_DIV), 32'd0);
      check_eq({tag, "_rst_tick"}, 32'(TICK), 32'd0);
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   initial begin
      logic held;
      RST_N = 1'b0;
      idle_inputs();
      EN = '0;
      model_reset();
      #1;
      check_eq("por_div", 32'(CLK_DIV), 32'd0);
      check_eq("por_tick", 32'(TICK), 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;

      // 1. free-running reset limits
      idle_inputs();
      run_ticks("t1");

      // 2. load at terminal count: toggles on old lim, next half period 6
      SYNC = 1'b1;
      cycle();
      SYNC = 1'b0;
      repeat (2) cycle();
      LD_EN = 1'b1; LD_CH = 4'd2; LD_VAL = 8'd5;
      cycle();
      LD_EN = 1'b0;
      check_eq("t2_tick_old_lim", 32'(TICK[2]), 32'd1);
      repeat (5) cycle();
      check_eq("t2_hold", 32'(CLK_DIV[2]), 32'd1);
      cycle();
      check_eq("t2_toggle", 32'(CLK_DIV[2]), 32'd0);

      // 3. lowering lim below running count (load coincides with SYNC)
      SYNC = 1'b1; LD_EN = 1'b1; LD_CH = 4'd2; LD_VAL = 8'd10;
      cycle();
      SYNC = 1'b0; LD_EN = 1'b0;
      repeat (7) cycle();
      LD_EN = 1'b1; LD_VAL = 8'd3;
      cycle();
      LD_EN = 1'b0;
      check_eq("t3_no_toggle_yet", 32'(CLK_DIV[2]), 32'd0);
      cycle();
      check_eq("t3_wrap_tick", 32'(TICK[2]), 32'd1);
      repeat (3) cycle();
      check_eq("t3_hold", 32'(CLK_DIV[2]), 32'd1);
      cycle();
      check_eq("t3_period4", 32'(CLK_DIV[2]), 32'd0);

      // 4. freeze channel 1 mid-count
      LD_EN = 1'b1; LD_CH = 4'd1; LD_VAL = 8'd4;
      cycle();
      LD_EN = 1'b0;
      repeat (3) cycle();
      held = m_div[1];
      EN[1] = 1'b0;
      repeat (5) begin
         cycle();
         check_eq("t4_frozen_tick", 32'(TICK[1]), 32'd0);
         check_eq("t4_frozen_div", 32'(CLK_DIV[1]), 32'(held));
      end
      EN[1] = 1'b1;
      repeat (12) cycle();

      // 5. SYNC with channels out of phase; limits now {0,4,3}
      SYNC = 1'b1;
      cycle();
      SYNC = 1'b0;
      check_eq("t5_sync_div", 32'(CLK_DIV), 32'd0);
      first_ticks("t5", 0, 4, 3);

      // 6. out-of-range load ignored, then async reset restores limits
      SYNC = 1'b1; LD_EN = 1'b1; LD_CH = 4'd3; LD_VAL = 8'd9;
      cycle();
      SYNC = 1'b0; LD_EN = 1'b0;
      first_ticks("t6", 0, 4, 3);
      repeat (3) cycle();
      async_reset("t6");
      run_ticks("t6");

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < NCH; i++) EN[i] = ($urandom_range(0, 7) != 0);
         SYNC   = ($urandom_range(0, 49) == 0);
         LD_EN  = ($urandom_range(0, 9) == 0);
         LD_CH  = 4'($urandom_range(0, 4));
         LD_VAL = 8'($urandom_range(0, 12));
         if ($urandom_range(0, 399) == 0) async_reset("rnd");
         else cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
